lut_neuron_layer_pipe: RTL and testbench

//  Parametrised, pipelined layer of truth-table neurons. Successor to the fixed 6-in/2-out combinational layer ROMs.

---
 rtl/lut_layer_pkg.sv | 26 ++
 rtl/lut_neuron_layer_pipe_if.sv | 29 ++
 rtl/lut_neuron_table.sv | 30 +++
 rtl/lut_neuron_layer_pipe.sv | 104 ++++++++++
 tb/tb_lut_neuron_layer_pipe.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/lut_layer_pkg.sv
// Shared constants, config record type and slice-index helpers for the
// truth-table neuron layer.
package lut_layer_pkg;

  localparam int NEURONS_DEF    = 16;
  localparam int FANIN_BITS_DEF = 6;
  localparam int OUT_BITS_DEF   = 2;
  localparam int TABLE_DEPTH    = 2 ** FANIN_BITS_DEF;
  // Wide enough to express index NEURONS itself so the error path is reachable.
  localparam int NIDX_W_DEF     = $clog2(NEURONS_DEF + 1);

  typedef struct packed {
    logic [NIDX_W_DEF-1:0]     neuron;
    logic [FANIN_BITS_DEF-1:0] addr;
    logic [OUT_BITS_DEF-1:0]   data;
  } cfg_wr_t;

  function automatic int in_lsb(int n, int fanin_bits);
    return n * fanin_bits;
  endfunction

  function automatic int out_lsb(int n, int out_bits);
    return n * out_bits;
  endfunction

endpackage

// File: rtl/lut_neuron_layer_pipe_if.sv
// Stream and table-config signals of the neuron layer, grouped for port use.
interface lut_neuron_layer_pipe_if #(
  parameter int NEURONS    = 16,
  parameter int FANIN_BITS = 6,
  parameter int OUT_BITS   = 2,
  parameter int NIDX_W     = $clog2(NEURONS + 1)
);
  logic                         in_valid;
  logic                         in_ready;
  logic [NEURONS*FANIN_BITS-1:0] in_data;
  logic                         out_valid;
  logic                         out_ready;
  logic [NEURONS*OUT_BITS-1:0]  out_data;
  logic                         cfg_we;
  logic [NIDX_W-1:0]            cfg_neuron;
  logic [FANIN_BITS-1:0]        cfg_addr;
  logic [OUT_BITS-1:0]          cfg_data;
  logic                         cfg_err;

  modport master (
    output in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    input  in_ready, out_valid, out_data, cfg_err
  );

  modport slave (
    input  in_valid, in_data, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
    output in_ready, out_valid, out_data, cfg_err
  );
endinterface

// File: rtl/lut_neuron_table.sv
// One neuron: runtime-loadable truth table with a single write port and a
// combinational read port.
module lut_neuron_table #(
  parameter int FANIN_BITS = 6,
  parameter int OUT_BITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [FANIN_BITS-1:0] waddr,
  input  logic [OUT_BITS-1:0]   wdata,
  input  logic [FANIN_BITS-1:0] raddr,
  output logic [OUT_BITS-1:0]   rdata
);
  localparam int DEPTH = 2 ** FANIN_BITS;

  logic [OUT_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read sees pre-edge contents, so a same-edge write returns the old value.
  assign rdata = mem[raddr];

endmodule

// File: rtl/lut_neuron_layer_pipe.sv
// Pipelined layer of truth-table neurons: table lookup into a main output
// register backed by one skid register, plus table config decode.
//
//  state    | meaning
//  ST_EMPTY | main register empty, skid empty
//  ST_MAIN  | main register holds a vector, skid empty
//  ST_BOTH  | main and skid both hold vectors, input stalled
module lut_neuron_layer_pipe
  import lut_layer_pkg::*;
#(
  parameter int NEURONS    = NEURONS_DEF,
  parameter int FANIN_BITS = FANIN_BITS_DEF,
  parameter int OUT_BITS   = OUT_BITS_DEF,
  parameter int NIDX_W     = $clog2(NEURONS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  lut_neuron_layer_pipe_if.slave  bus
);

  typedef enum logic [1:0] {ST_EMPTY, ST_MAIN, ST_BOTH} state_t;

  state_t state_q, state_d;
  logic   load_main, load_skid, main_from_skid;
  logic   accept;
  logic   cfg_err_q;

  logic [NEURONS*OUT_BITS-1:0] lookup, main_q, skid_q;

  for (genvar n = 0; n < NEURONS; n++) begin : g_neuron
    localparam int IL = in_lsb(n, FANIN_BITS);
    localparam int OL = out_lsb(n, OUT_BITS);

    lut_neuron_table #(
      .FANIN_BITS (FANIN_BITS),
      .OUT_BITS   (OUT_BITS)
    ) u_table (
      .clk   (clk),
      .rst   (rst),
      .we    (bus.cfg_we && (bus.cfg_neuron == NIDX_W'(n))),
      .waddr (bus.cfg_addr),
      .wdata (bus.cfg_data),
      .raddr (bus.in_data[IL +: FANIN_BITS]),
      .rdata (lookup[OL +: OUT_BITS])
    );
  end

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          load_main = 1'b1;
          state_d   = ST_MAIN;
        end
      end
      ST_MAIN: begin
        if (bus.out_ready) begin
          if (accept) load_main = 1'b1;
          else        state_d   = ST_EMPTY;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = ST_BOTH;
        end
      end
      ST_BOTH: begin
        if (bus.out_ready) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_MAIN;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q    <= '0;
      skid_q    <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : lookup;
      if (load_skid) skid_q <= lookup;
      cfg_err_q <= bus.cfg_we && (bus.cfg_neuron >= NIDX_W'(NEURONS));
    end
  end

  assign bus.in_ready  = (state_q != ST_BOTH);
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign bus.out_data  = main_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Directed, table-driven bench for the truth-table neuron layer.
module tb_lut_neuron_layer_pipe;
  import lut_layer_pkg::*;

  localparam int N  = 16;
  localparam int F  = 6;
  localparam int O  = 2;
  localparam int NW = $clog2(N + 1);

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lut_neuron_layer_pipe_if #(.NEURONS(N), .FANIN_BITS(F), .OUT_BITS(O), .NIDX_W(NW)) bus ();

  lut_neuron_layer_pipe #(.NEURONS(N), .FANIN_BITS(F), .OUT_BITS(O), .NIDX_W(NW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N*F-1:0] din;
    logic [N*O-1:0] exp;
  } vec_t;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N*F-1:0] fill(input logic [F-1:0] v);
    logic [N*F-1:0] r;
    for (int n = 0; n < N; n++) r[n*F +: F] = v;
    return r;
  endfunction

  function automatic logic [N*F-1:0] din3(input int k);
    logic [N*F-1:0] r;
    r = fill(6'd62);
    r[F +: F]   = F'(k);
    r[2*F +: F] = F'(k);
    return r;
  endfunction

  function automatic logic [N*O-1:0] exp3(input int k);
    return (32'(k % 4) << 2) | (32'(k / 4) << 4);
  endfunction

  task automatic cfg_write(input cfg_wr_t w);
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = w.neuron;
    bus.cfg_addr   = w.addr;
    bus.cfg_data   = w.data;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    vec_t      vt[4];
    cfg_wr_t   wt[4];
    logic      ir_exp[7];
    logic [N*F-1:0] d;
    int sent, rcv;
    logic acc, pop;

    wt[0] = '{neuron: 5'd0,  addr: 6'd0,  data: 2'd3};
    wt[1] = '{neuron: 5'd0,  addr: 6'd1,  data: 2'd2};
    wt[2] = '{neuron: 5'd0,  addr: 6'd49, data: 2'd1};
    wt[3] = '{neuron: 5'd15, addr: 6'd63, data: 2'd1};
    d = fill(6'd62); d[0 +: F] = 6'd0;  vt[0] = '{din: d, exp: 32'h0000_0003};
    d = fill(6'd62); d[0 +: F] = 6'd1;  vt[1] = '{din: d, exp: 32'h0000_0002};
    d = fill(6'd62); d[0 +: F] = 6'd49; vt[2] = '{din: d, exp: 32'h0000_0001};
    vt[3] = '{din: fill(6'd63), exp: 32'h4000_0000};
    ir_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b1;
    bus.cfg_we     = 1'b0;
    bus.cfg_neuron = '0;
    bus.cfg_addr   = '0;
    bus.cfg_data   = '0;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  64'(bus.out_data),  64'd0);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_cfg_err",   64'(bus.cfg_err),   64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // 1: idle tables, all-ones input
    bus.in_data  = '1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_out_data",  64'(bus.out_data),  64'd0);
    chk("t1_in_ready",  64'(bus.in_ready),  64'd1);
    tick();
    chk("t1_drained", 64'(bus.out_valid), 64'd0);

    // 2: load tables, stream patterns back-to-back
    for (int i = 0; i < 4; i++) cfg_write(wt[i]);
    chk("t2_cfg_err_valid_write", 64'(bus.cfg_err), 64'd0);
    bus.in_data  = vt[0].din;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) bus.in_data = vt[i+1].din;
      else       bus.in_valid = 1'b0;
      chk($sformatf("t2_valid_%0d", i), 64'(bus.out_valid), 64'd1);
      chk($sformatf("t2_data_%0d", i),  64'(bus.out_data),  64'(vt[i].exp));
    end

    // 3: tag vectors through neurons 1 and 2, stall output on cycles 2-4
    for (int k = 0; k < 8; k++) begin
      cfg_write('{neuron: 5'd1, addr: 6'(k), data: 2'(k % 4)});
      cfg_write('{neuron: 5'd2, addr: 6'(k), data: 2'(k / 4)});
    end
    tick();
    chk("t3_idle", 64'(bus.out_valid), 64'd0);
    sent = 0;
    rcv  = 0;
    for (int c = 0; c < 40 && rcv < 8; c++) begin
      bus.in_valid  = (sent < 8);
      bus.in_data   = din3(sent);
      bus.out_ready = !(c >= 2 && c <= 4);
      if (c <= 6) chk($sformatf("t3_in_ready_c%0d", c), 64'(bus.in_ready), 64'(ir_exp[c]));
      acc = bus.in_valid && bus.in_ready;
      pop = bus.out_valid && bus.out_ready;
      if (pop) begin
        chk($sformatf("t3_order_%0d", rcv), 64'(bus.out_data), 64'(exp3(rcv)));
        rcv++;
      end
      tick();
      if (acc) sent++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("t3_received", 64'(rcv), 64'd8);
    chk("t3_no_extra", 64'(bus.out_valid), 64'd0);

    // 4: same-edge write and lookup of one entry
    d = fill(6'd62);
    d[3*F +: F] = 6'd5;
    bus.in_data    = d;
    bus.in_valid   = 1'b1;
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 5'd3;
    bus.cfg_addr   = 6'd5;
    bus.cfg_data   = 2'b10;
    tick();
    bus.cfg_we = 1'b0;
    chk("t4_old_value", 64'(bus.out_data), 64'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("t4_new_valid", 64'(bus.out_valid), 64'd1);
    chk("t4_new_value", 64'(bus.out_data), 64'h80);
    tick();

    // 5: out-of-range neuron index
    bus.cfg_we     = 1'b1;
    bus.cfg_neuron = 5'd16;
    bus.cfg_addr   = 6'd62;
    bus.cfg_data   = 2'b11;
    tick();
    bus.cfg_we = 1'b0;
    chk("t5_err_pulse", 64'(bus.cfg_err), 64'd1);
    tick();
    chk("t5_err_clear", 64'(bus.cfg_err), 64'd0);
    bus.in_data  = fill(6'd62);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t5_no_write", 64'(bus.out_data), 64'd0);
    tick();

    // 6: reset with main and skid full
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = din3(1);
    tick();
    bus.in_data = din3(2);
    tick();
    bus.in_valid = 1'b0;
    chk("t6_full_in_ready", 64'(bus.in_ready),  64'd0);
    chk("t6_full_valid",    64'(bus.out_valid), 64'd1);
    chk("t6_full_data",     64'(bus.out_data),  64'(exp3(1)));
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid",    64'(bus.out_valid), 64'd0);
    chk("t6_rst_in_ready", 64'(bus.in_ready),  64'd1);
    chk("t6_rst_data",     64'(bus.out_data),  64'd0);
    #2 rst = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    chk("t6_skid_discarded", 64'(bus.out_valid), 64'd0);
    chk("t6_in_ready",       64'(bus.in_ready),  64'd1);
    d = din3(3);
    d[0 +: F] = 6'd0;
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    chk("t6_post_valid",   64'(bus.out_valid), 64'd1);
    chk("t6_tables_clear", 64'(bus.out_data),  64'd0);
    tick();
    chk("t6_post_drain", 64'(bus.out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
